// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module  : mem_port_arbiter
// Brief   : Single-outstanding arbiter sharing one memory port between
//           instruction fetch and data load/store, with fetch starvation guard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  input  logic                  if_kill_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  input  logic [2:0]            d_funct3_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [2:0]            mem_funct3_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  stall_f_o,
  output logic                  stall_m_o
);

  localparam int C_LAT_W = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;
  localparam int C_ST_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [2:0] C_FETCH_FUNCT3 = 3'b010;

  generate
    if (MEM_LATENCY < 1) begin : g_bad_latency
      $error("mem_port_arbiter: MEM_LATENCY must be >= 1");
    end
  endgenerate

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [C_LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [C_ST_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic               owner_q, owner_d;       // 1 = data, 0 = fetch
  logic               owner_we_q, owner_we_d;
  logic               kill_pend_q, kill_pend_d;

  logic w_resp, w_arb, w_f_elig, w_starved, w_d_gnt, w_f_gnt;
  logic w_if_rvalid, w_d_rvalid;

  always_comb begin
    w_resp    = (state_q == S_BUSY) && (lat_cnt_q == C_LAT_W'(MEM_LATENCY));
    w_arb     = (state_q == S_IDLE) || w_resp;
    // A kill arriving alongside an idle fetch request means the fetch is already stale.
    w_f_elig  = if_req_i && !((state_q == S_IDLE) && if_kill_i);
    w_starved = if_req_i && (starve_cnt_q == C_ST_W'(STARVE_LIMIT));
    w_d_gnt   = rst_i && w_arb && d_req_i && !(w_starved && w_f_elig);
    w_f_gnt   = rst_i && w_arb && w_f_elig && !w_d_gnt;
    w_if_rvalid = rst_i && w_resp && !owner_q && !kill_pend_q && !if_kill_i;
    w_d_rvalid  = rst_i && w_resp && owner_q;
  end

  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    owner_d      = owner_q;
    owner_we_d   = owner_we_q;
    kill_pend_d  = kill_pend_q;
    starve_cnt_d = starve_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (w_d_gnt || w_f_gnt) begin
          state_d   = S_BUSY;
          lat_cnt_d = C_LAT_W'(1);
        end
      end
      S_BUSY: begin
        if (w_resp) begin
          if (w_d_gnt || w_f_gnt) begin
            lat_cnt_d = C_LAT_W'(1);
          end else begin
            state_d   = S_IDLE;
            lat_cnt_d = '0;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + C_LAT_W'(1);
        end
      end
      default: begin
        state_d   = S_IDLE;
        lat_cnt_d = '0;
      end
    endcase

    if (w_d_gnt || w_f_gnt) begin
      owner_d    = w_d_gnt;
      owner_we_d = w_d_gnt && d_we_i;
    end

    if (w_resp) kill_pend_d = 1'b0;
    if ((state_q == S_BUSY) && !w_resp && !owner_q && if_kill_i) kill_pend_d = 1'b1;
    if (w_f_gnt && if_kill_i) kill_pend_d = 1'b1;

    if (!if_req_i || w_f_gnt) begin
      starve_cnt_d = '0;
    end else if (w_d_gnt && (starve_cnt_q != C_ST_W'(STARVE_LIMIT))) begin
      starve_cnt_d = starve_cnt_q + C_ST_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      owner_q      <= 1'b0;
      owner_we_q   <= 1'b0;
      kill_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      owner_q      <= owner_d;
      owner_we_q   <= owner_we_d;
      kill_pend_q  <= kill_pend_d;
    end
  end

  always_comb begin
    if_gnt_o     = w_f_gnt;
    d_gnt_o      = w_d_gnt;
    if_rvalid_o  = w_if_rvalid;
    if_rdata_o   = w_if_rvalid ? mem_rdata_i : '0;
    d_rvalid_o   = w_d_rvalid;
    d_rdata_o    = (w_d_rvalid && !owner_we_q) ? mem_rdata_i : '0;
    mem_en_o     = w_d_gnt || w_f_gnt;
    mem_we_o     = w_d_gnt && d_we_i;
    mem_addr_o   = w_d_gnt ? d_addr_i   : (w_f_gnt ? if_addr_i : '0);
    mem_wdata_o  = (w_d_gnt && d_we_i) ? d_wdata_i : '0;
    mem_funct3_o = w_d_gnt ? d_funct3_i : (w_f_gnt ? C_FETCH_FUNCT3 : 3'b000);
    stall_f_o    = rst_i && if_req_i && !w_if_rvalid;
    stall_m_o    = rst_i && d_req_i && !w_d_rvalid;
  end

endmodule

`default_nettype wire
